// File: rtl/d_latch_pkg.sv
// Shared definitions for the d_latch block.
package d_latch_pkg;

    // Default data width of the latch when the instantiating code does not override it.
    localparam int DLATCH_DEFAULT_W = 1;

endpackage : d_latch_pkg

// File: rtl/d_latch.sv
// Clocked emulation of a gated D latch. A registered copy of D is kept while
// the gate is open, and the output is a combinational mux between the live
// input (gate open) and the stored copy (gate closed). No real latch is
// inferred anywhere.
module d_latch
    import d_latch_pkg::*;
#(
    parameter int               WIDTH   = DLATCH_DEFAULT_W,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] D,
    input  logic             En,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] w_q;

    // Storage: reset wins over the gate; an open gate captures D at every edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hold_q <= RST_VAL;
        end else if (En) begin
            hold_q <= D;
        end
    end

    // Transparency mux: open gate passes D straight through, closed gate shows the stored value.
    always_comb begin
        w_q = hold_q;
        if (En) begin
            w_q = D;
        end
    end

    assign Q  = w_q;
    assign Qn = ~w_q;

endmodule : d_latch

// File: tb/tb_d_latch.sv
// Self-checking bench for d_latch: a 1-bit default instance and an 8-bit
// instance with a non-zero reset value, sharing clock, reset and gate.
module tb_d_latch;

    logic       clk;
    logic       rst;
    logic       en;
    logic       d1;
    logic [7:0] d8;
    logic       q1, qn1;
    logic [7:0] q8, qn8;

    int n_checks;
    int n_fail;

    // Reference state: the value the latch is holding, as the rules define it.
    logic       m1;
    logic [7:0] m8;

    d_latch u_dut1 (
        .Clk (clk),
        .Rst (rst),
        .D   (d1),
        .En  (en),
        .Q   (q1),
        .Qn  (qn1)
    );

    d_latch #(
        .WIDTH   (8),
        .RST_VAL (8'hA5)
    ) u_dut8 (
        .Clk (clk),
        .Rst (rst),
        .D   (d8),
        .En  (en),
        .Q   (q8),
        .Qn  (qn8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output: live input while the gate is open, otherwise the held value.
    function automatic logic exp_q1();
        return en ? d1 : m1;
    endfunction

    function automatic logic [7:0] exp_q8();
        return en ? d8 : m8;
    endfunction

    // Advance one rising edge, updating the reference from the inputs present at the edge.
    task automatic tick();
        logic       r, e, dv1;
        logic [7:0] dv8;
        r   = rst;
        e   = en;
        dv1 = d1;
        dv8 = d8;
        @(posedge clk);
        if (r) begin
            m1 = 1'b0;
            m8 = 8'hA5;
        end else if (e) begin
            m1 = dv1;
            m8 = dv8;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; d1 = 1'b1; d8 = 8'hFF;
        tick();
        n_checks++;
        if (q1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_q1: got %b expected 0", q1);
        end
        n_checks++;
        if (qn1 !== 1'b1) begin
            n_fail++; $display("FAIL reset_qn1: got %b expected 1", qn1);
        end
        n_checks++;
        if (q8 !== 8'hA5) begin
            n_fail++; $display("FAIL reset_q8: got %h expected a5", q8);
        end
        n_checks++;
        if (qn8 !== 8'h5A) begin
            n_fail++; $display("FAIL reset_qn8: got %h expected 5a", qn8);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (q8 !== 8'hA5 || q1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold: got q1=%b q8=%h expected 0 a5", q1, q8);
        end
    endtask

    task automatic test_transparency();
        logic [2:0] pat;
        pat = 3'b010;
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            d1 = pat[i];
            d8 = {8{pat[i]}} ^ 8'h96;
            #1;
            n_checks++;
            if (q1 !== pat[i] || qn1 !== ~pat[i]) begin
                n_fail++; $display("FAIL transp_q1[%0d]: got q=%b qn=%b expected q=%b", i, q1, qn1, pat[i]);
            end
            n_checks++;
            if (q8 !== ({8{pat[i]}} ^ 8'h96) || qn8 !== ~q8) begin
                n_fail++; $display("FAIL transp_q8[%0d]: got q=%h qn=%h expected q=%h", i, q8, qn8, {8{pat[i]}} ^ 8'h96);
            end
        end
        tick();
    endtask

    task automatic test_hold();
        rst = 1'b0; en = 1'b1; d1 = 1'b1; d8 = 8'h5C;
        tick();
        en = 1'b0; d1 = 1'b0; d8 = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (q1 !== 1'b1 || qn1 !== 1'b0) begin
                n_fail++; $display("FAIL hold_q1[%0d]: got q=%b qn=%b expected q=1 qn=0", i, q1, qn1);
            end
            n_checks++;
            if (q8 !== 8'h5C) begin
                n_fail++; $display("FAIL hold_q8[%0d]: got %h expected 5c", i, q8);
            end
        end
    endtask

    task automatic test_reset_vs_enable();
        rst = 1'b1; en = 1'b1; d1 = 1'b1; d8 = 8'h11;
        #1;
        n_checks++;
        if (q1 !== 1'b1 || q8 !== 8'h11) begin
            n_fail++; $display("FAIL rst_transp: got q1=%b q8=%h expected 1 11", q1, q8);
        end
        tick();
        rst = 1'b0; en = 1'b0;
        #1;
        n_checks++;
        if (q1 !== 1'b0 || qn1 !== 1'b1) begin
            n_fail++; $display("FAIL rst_dominates_q1: got q=%b qn=%b expected q=0 qn=1", q1, qn1);
        end
        n_checks++;
        if (q8 !== 8'hA5 || qn8 !== 8'h5A) begin
            n_fail++; $display("FAIL rst_dominates_q8: got q=%h qn=%h expected a5 5a", q8, qn8);
        end
        tick();
    endtask

    task automatic test_width();
        rst = 1'b0; en = 1'b1; d8 = 8'h3C;
        tick();
        en = 1'b0;
        #1;
        n_checks++;
        if (q8 !== 8'h3C || qn8 !== 8'hC3) begin
            n_fail++; $display("FAIL width_capture: got q=%h qn=%h expected 3c c3", q8, qn8);
        end
        // Late D change while still open must pass through but not be held.
        en = 1'b1; d8 = 8'h3C;
        tick();
        d8 = 8'h77;
        #1;
        n_checks++;
        if (q8 !== 8'h77) begin
            n_fail++; $display("FAIL width_late_transp: got %h expected 77", q8);
        end
        en = 1'b0;
        #1;
        n_checks++;
        if (q8 !== 8'h3C || qn8 !== 8'hC3) begin
            n_fail++; $display("FAIL width_late_not_held: got q=%h qn=%h expected 3c c3", q8, qn8);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 7) == 0);
            en  = $urandom_range(0, 1);
            d1  = $urandom_range(0, 1);
            d8  = 8'($urandom);
            #1;
            n_checks++;
            if (q1 !== exp_q1() || qn1 !== ~exp_q1()) begin
                n_fail++; $display("FAIL rand_q1[%0d]: got q=%b qn=%b expected q=%b", i, q1, qn1, exp_q1());
            end
            n_checks++;
            if (q8 !== exp_q8() || qn8 !== ~exp_q8()) begin
                n_fail++; $display("FAIL rand_q8[%0d]: got q=%h qn=%h expected q=%h", i, q8, qn8, exp_q8());
            end
            // Mid-cycle D change exercises the combinational path between edges.
            d8 = 8'($urandom);
            d1 = ~d1;
            #1;
            n_checks++;
            if (q8 !== exp_q8() || q1 !== exp_q1()) begin
                n_fail++; $display("FAIL rand_mid[%0d]: got q1=%b q8=%h expected %b %h", i, q1, q8, exp_q1(), exp_q8());
            end
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m1  = 1'bx;
        m8  = 8'hxx;
        rst = 1'b1;
        en  = 1'b0;
        d1  = 1'b0;
        d8  = 8'h00;
        #1;
        test_reset();
        test_transparency();
        test_hold();
        test_reset_vs_enable();
        test_width();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_d_latch

// File: doc/d_latch.md
D_LATCH -- requirements
Module: d_latch

Interface
REQ-001 Parameter WIDTH, default 1, data width of D, Q and Qn.
REQ-002 Parameter RST_VAL, default all-zeros, value loaded into the stored state by reset.
REQ-003 Clk  input  1  system clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 D    input  WIDTH  data input.
REQ-006 En   input  1  latch gate; 1 = transparent, 0 = hold.
REQ-007 Q    output  WIDTH  latch output.
REQ-008 Qn   output  WIDTH  bitwise complement of Q.
REQ-009 Instantiations SHALL use named port connections; port order is not part of the interface.

Function
REQ-010 Module SHALL hold one WIDTH-bit storage register, hold_q, clocked on rising Clk.
REQ-011 En=1: Q SHALL equal D combinationally, with zero-cycle latency, and SHALL follow D changes between clock edges.
REQ-012 En=0: Q SHALL equal hold_q.
REQ-013 Rising Clk with Rst=0 and En=1: hold_q SHALL load D.
REQ-014 Rising Clk with Rst=0 and En=0: hold_q SHALL keep its value.
REQ-015 After En falls, Q SHALL present the D value captured at the last rising Clk with En=1.
REQ-016 D changes after that capture edge and before En falls SHALL NOT be held.
REQ-017 Qn SHALL equal ~Q at all times, including during and after reset, for every bit.
REQ-018 Module SHALL contain no inferred latches; transparency SHALL be a combinational mux of D and hold_q.
REQ-019 Module SHALL have no other state, no handshake and no status outputs.

Reset
REQ-020 Rising Clk with Rst=1: hold_q SHALL load RST_VAL, regardless of En and D.
REQ-021 Rst SHALL dominate En at the clock edge.
REQ-022 Rst=1 with En=1: Q SHALL still follow D (transparent path).
REQ-023 Once En=0, Q SHALL show RST_VAL if a reset edge was the last update.
REQ-024 Rst=1 with En=0: Q SHALL show RST_VAL from the first reset edge onward.
REQ-025 Before the first reset edge, hold_q is undefined; the bench SHALL NOT check Q or Qn then with En=0.

Structure
REQ-026 Module SHALL be a single flat module with no sub-modules.
REQ-027 A shared package is not required.
REQ-028 WIDTH and RST_VAL SHALL be module parameters.

Verification
REQ-029 Reset: Rst=1 one edge, En=0, D=1 -> Q=0, Qn=1 after the edge.
REQ-030 Transparency: Rst=0, En=1, D toggles 0->1->0 mid-cycle -> Q tracks D immediately each time, Qn is its inverse.
REQ-031 Hold: En=1, D=1, one rising edge, then En=0 and D=0 -> Q stays 1 for 5 cycles, Qn=0.
REQ-032 Reset vs enable: Rst=1, En=1, D=1 at an edge, then Rst=0, En=0 -> Q=0.
REQ-033 Width: WIDTH=8, RST_VAL=8'hA5, reset then En=0 -> Q=8'hA5, Qn=8'h5A.
REQ-034 Same WIDTH=8 setup: En=1, D=8'h3C, one edge, En=0 -> Q=8'h3C, Qn=8'hC3.
